// File: rtl/pmem_model.sv
// pmem_model: behavioural 64-bit-word main memory serving cache line-fill reads (PMEM_WRITE_EN adds a write port).
// Latency: mem_data_valid pulses LATENCY cycles after a read is accepted; mem_data is registered and held.
// Backpressure: none; requests are taken only in IDLE, anything arriving while busy is dropped, no queueing.
module pmem_model #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic [31:0] mem_addr,
`ifdef PMEM_WRITE_EN
  input  logic        mem_wr_en,
  input  logic [63:0] mem_wr_data,
`endif
  output logic [63:0] mem_data,
  output logic        mem_data_valid
);

  // cnt counts down from LATENCY-2, so it only needs to hold that value
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] idx, idx_d;
  logic [AW-1:0] addr_idx;
  logic [63:0]   rd_word;
  logic [63:0]   data_d;
  logic          valid_d;
  logic          wr_acc;

  // Power-on contents: upper half is the word index, lower half tags it with DEAD.
  function automatic logic [63:0] init_word(input logic [AW-1:0] i);
    logic [31:0] w;
    w = 32'(i);
    return {w, 16'hDEAD, w[15:0]};
  endfunction

  // Byte offset and high address bits are dropped, so addresses wrap every DEPTH*8 bytes.
  assign addr_idx = mem_addr[AW+2:3];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+3], mem_addr[2:0]};

`ifdef PMEM_WRITE_EN
  // Words never written read back their power-on pattern; the flags make that
  // pattern visible without an explicit initialisation pass over the array.
  logic [63:0]      mem [DEPTH];
  logic [DEPTH-1:0] written = '0;

  // A write in IDLE takes priority over a read issued in the same cycle.
  assign wr_acc  = (state == IDLE) && mem_wr_en;
  assign rd_word = written[idx_d] ? mem[idx_d] : init_word(idx_d);

  // Array update; reset deliberately leaves contents untouched
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[addr_idx]     <= mem_wr_data;
      written[addr_idx] <= 1'b1;
    end
  end
`else
  // Read-only build: contents are exactly the power-on pattern, computed from the index.
  assign wr_acc  = 1'b0;
  assign rd_word = init_word(idx_d);
`endif

  // State register: FSM state, wait counter and latched word index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    case (state)
      IDLE: begin
        if (mem_rd_en && !wr_acc) begin
          idx_d = addr_idx;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = RESP;
        else           cnt_d   = cnt - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: load the response register on entry to RESP, otherwise hold
  always_comb begin
    valid_d = (state_d == RESP);
    data_d  = valid_d ? rd_word : mem_data;
  end

  // Response register: valid pulse coincides with RESP, data held until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_data       <= '0;
      mem_data_valid <= 1'b0;
    end else begin
      mem_data       <= data_d;
      mem_data_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_pmem_model.sv
// tb_pmem_model: bench for pmem_model with directed scenarios and randomized traffic.
// Expected values come from an address-to-word rule plus a request timeline model.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_pmem_model;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd_en = 1'b0;
  logic [31:0] mem_addr = '0;
`ifdef PMEM_WRITE_EN
  logic        mem_wr_en = 1'b0;
  logic [63:0] mem_wr_data = '0;
  logic [63:0] wr_mem [int];
`endif
  logic [63:0] mem_data;
  logic        mem_data_valid;

  int checks = 0;
  int passed = 0;

  // Reference timeline: edge counter, first edge at which a request may be taken,
  // edge after which the pending response shows, and the expected outputs.
  int          edge_n = 0;
  int          free_edge = 0;
  int          pend_edge = -1;
  logic [63:0] pend_data = '0;
  logic [63:0] exp_data = '0;
  logic        exp_valid = 1'b0;

  pmem_model #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
`ifdef PMEM_WRITE_EN
    .mem_wr_en      (mem_wr_en),
    .mem_wr_data    (mem_wr_data),
`endif
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid)
  );

  always #5 clk = ~clk;

  function automatic int word_index(input logic [31:0] addr);
    return int'((addr >> 3) % 32'(DEPTH));
  endfunction

  function automatic logic [63:0] ref_word(input logic [31:0] addr);
    logic [31:0] i;
    i = 32'(word_index(addr));
`ifdef PMEM_WRITE_EN
    if (wr_mem.exists(int'(i))) return wr_mem[int'(i)];
`endif
    return {i, 32'hDEAD0000 | (i & 32'h0000FFFF)};
  endfunction

  task automatic model_reset();
    pend_edge = -1;
    free_edge = 0;
    exp_data  = '0;
    exp_valid = 1'b0;
  endtask

  // Advance one clock and update the reference timeline; returns at the falling edge.
  task automatic cycle();
    bit wr_taken;
    @(posedge clk);
    edge_n++;
    wr_taken = 1'b0;
    if (rst && edge_n >= free_edge) begin
`ifdef PMEM_WRITE_EN
      if (mem_wr_en) begin
        wr_mem[word_index(mem_addr)] = mem_wr_data;
        wr_taken = 1'b1;
      end
`endif
      if (mem_rd_en && !wr_taken) begin
        pend_edge = edge_n + LATENCY - 1;
        pend_data = ref_word(mem_addr);
        free_edge = edge_n + LATENCY + 1;
      end
    end
    exp_valid = (pend_edge == edge_n);
    if (exp_valid) exp_data = pend_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (mem_data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", mem_data_valid);
      else passed++;
      checks++;
      if (mem_data !== 64'h0) $display("FAIL reset_data: got %h want 0", mem_data);
      else passed++;
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (mem_data_valid !== 1'b0) $display("FAIL idle_valid: cycle %0d got %b want 0", i, mem_data_valid);
      else passed++;
    end
  endtask

  task automatic test_basic_read();
    int pulses = 0;
    mem_addr  = 32'h40;
    mem_rd_en = 1'b1;
    cycle();
    mem_rd_en = 1'b0;
    mem_addr  = $urandom;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      if (mem_data_valid === 1'b1) pulses++;
      checks++;
      if (mem_data_valid !== (i == 3)) $display("FAIL basic_valid: cycle %0d got %b want %b", i, mem_data_valid, (i == 3));
      else passed++;
      if (i >= 3) begin
        checks++;
        if (mem_data !== 64'h00000008_DEAD0008) $display("FAIL basic_data: cycle %0d got %h want 00000008dead0008", i, mem_data);
        else passed++;
      end
    end
    checks++;
    if (pulses != 1) $display("FAIL basic_pulses: got %0d want 1", pulses);
    else passed++;
  endtask

  task automatic test_busy_drop_and_hold();
    int pulses = 0;
    int last_pulse = -1;
    mem_addr  = 32'h08;
    mem_rd_en = 1'b1;
    cycle();
    mem_rd_en = 1'b0;
    cycle();
    mem_addr  = 32'h10;
    mem_rd_en = 1'b1;
    cycle();
    mem_rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mem_data_valid === 1'b1) begin
        pulses++;
        checks++;
        if (mem_data !== 64'h00000001_DEAD0001) $display("FAIL busy_data: got %h want 00000001dead0001", mem_data);
        else passed++;
      end
      checks++;
      if (mem_data_valid !== exp_valid) $display("FAIL busy_valid: cycle %0d got %b want %b", i, mem_data_valid, exp_valid);
      else passed++;
      cycle();
    end
    checks++;
    if (pulses != 1) $display("FAIL busy_pulses: got %0d want 1", pulses);
    else passed++;

    // Level-held request: re-accepted right after each response
    pulses = 0;
    mem_addr  = 32'h10;
    mem_rd_en = 1'b1;
    for (int i = 0; i < 30 && pulses < 4; i++) begin
      cycle();
      checks++;
      if (mem_data_valid !== exp_valid) $display("FAIL hold_valid: edge %0d got %b want %b", edge_n, mem_data_valid, exp_valid);
      else passed++;
      if (mem_data_valid === 1'b1) begin
        pulses++;
        checks++;
        if (mem_data !== 64'h00000002_DEAD0002) $display("FAIL hold_data: got %h want 00000002dead0002", mem_data);
        else passed++;
        if (last_pulse >= 0) begin
          checks++;
          if (edge_n - last_pulse != LATENCY + 1) $display("FAIL hold_spacing: got %0d want %0d", edge_n - last_pulse, LATENCY + 1);
          else passed++;
        end
        last_pulse = edge_n;
      end
    end
    mem_rd_en = 1'b0;
    checks++;
    if (pulses != 4) $display("FAIL hold_pulses: got %0d want 4", pulses);
    else passed++;
    repeat (3) cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    logic [63:0] words [2];
    addrs[0] = 32'h0000_2008; words[0] = 64'h00000001_DEAD0001;
    addrs[1] = 32'h0000_1FFF; words[1] = 64'h000003FF_DEAD03FF;
    for (int k = 0; k < 2; k++) begin
      bit seen = 1'b0;
      mem_addr  = addrs[k];
      mem_rd_en = 1'b1;
      cycle();
      mem_rd_en = 1'b0;
      for (int i = 0; i < 2 * LATENCY + 2 && !seen; i++) begin
        cycle();
        if (mem_data_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) $display("FAIL wrap_timeout: addr %h no valid pulse", addrs[k]);
      else passed++;
      checks++;
      if (mem_data !== words[k]) $display("FAIL wrap_data: addr %h got %h want %h", addrs[k], mem_data, words[k]);
      else passed++;
      repeat (2) cycle();
    end
  endtask

  task automatic test_reset_mid_request();
    int pulses = 0;
    mem_addr  = 32'h40;
    mem_rd_en = 1'b1;
    cycle();
    mem_rd_en = 1'b0;
    cycle();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mem_data !== 64'h0) $display("FAIL midrst_async_data: got %h want 0", mem_data);
    else passed++;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (mem_data_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL midrst_late_pulse: got %0d pulses want 0", pulses);
    else passed++;
    checks++;
    if (mem_data !== 64'h0) $display("FAIL midrst_data: got %h want 0", mem_data);
    else passed++;
    mem_addr  = 32'h0000_0188;
    mem_rd_en = 1'b1;
    cycle();
    mem_rd_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < LATENCY + 3; i++) begin
      cycle();
      if (mem_data_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) $display("FAIL midrst_recover_pulses: got %0d want 1", pulses);
    else passed++;
    checks++;
    if (mem_data !== 64'h00000031_DEAD0031) $display("FAIL midrst_recover_data: got %h want 00000031dead0031", mem_data);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        model_reset();
        cycle();
        rst = 1'b1;
      end
      mem_rd_en = ($urandom_range(0, 2) == 0);
      mem_addr  = $urandom;
      cycle();
      checks++;
      if (mem_data_valid !== exp_valid) $display("FAIL rand_valid: edge %0d got %b want %b", edge_n, mem_data_valid, exp_valid);
      else passed++;
      checks++;
      if (mem_data !== exp_data) $display("FAIL rand_data: edge %0d got %h want %h", edge_n, mem_data, exp_data);
      else passed++;
    end
    mem_rd_en = 1'b0;
    repeat (LATENCY + 2) cycle();
  endtask

`ifdef PMEM_WRITE_EN
  task automatic test_write();
    int pulses = 0;
    logic [63:0] wval;
    mem_addr    = 32'h40;
    mem_wr_data = 64'h0123_4567_89AB_CDEF;
    mem_wr_en   = 1'b1;
    cycle();
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b1;
    cycle();
    mem_rd_en   = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      cycle();
      if (mem_data_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) $display("FAIL write_read_pulses: got %0d want 1", pulses);
    else passed++;
    checks++;
    if (mem_data !== 64'h0123_4567_89AB_CDEF) $display("FAIL write_read_data: got %h want 0123456789abcdef", mem_data);
    else passed++;

    wval        = {$urandom, $urandom};
    mem_addr    = 32'h80;
    mem_wr_data = wval;
    mem_wr_en   = 1'b1;
    mem_rd_en   = 1'b1;
    cycle();
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    pulses = 0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      cycle();
      if (mem_data_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL write_wins_pulse: got %0d want 0", pulses);
    else passed++;
    mem_rd_en = 1'b1;
    cycle();
    mem_rd_en = 1'b0;
    for (int i = 0; i < LATENCY + 2; i++) cycle();
    checks++;
    if (mem_data !== wval) $display("FAIL write_wins_data: got %h want %h", mem_data, wval);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_read();
    test_busy_drop_and_hold();
    test_wrap();
    test_reset_mid_request();
    test_random();
`ifdef PMEM_WRITE_EN
    test_write();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
